axi_lite_preset_loader: RTL and testbench

- AXI4-Lite write-only master that copies one synth preset (carrier wavetable, modulator wavetable, envelope/volume control word) from a synchronous preset ROM into the synth control/status register bank.
- Sits between the preset ROM and the register-bank slave port, behind a 2:1 interconnect shared with the PS master.
- Writes words in ascending address order, so the control word (last index) lands after both wavetables.

---
 rtl/axi_lite_preset_loader.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_axi_lite_preset_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_preset_loader.sv
// AXI4-Lite write-only master that copies one preset (C_NUM_REG words) from a synchronous ROM
// into the synth register bank. Optional stall watchdog: define LOADER_TIMEOUT_EN.
module axi_lite_preset_loader #(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_NUM_REG    = 33,
   parameter int C_ADDR_WIDTH = $clog2(C_NUM_REG) + 2,
   parameter int C_NUM_PRESET = 8,
   parameter int C_PSEL_WIDTH = $clog2(C_NUM_PRESET),
   parameter int C_TIMEOUT    = 255
) (
   input  logic                                   s_axi_aclk,
   input  logic                                   s_axi_aresetn,
   input  logic                                   start,
   input  logic [C_PSEL_WIDTH-1:0]                preset_sel,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   err,
   output logic [C_ADDR_WIDTH-3:0]                err_idx,
   output logic [C_PSEL_WIDTH+C_ADDR_WIDTH-3:0]   rom_addr,
   output logic                                   rom_en,
   input  logic [C_DATA_WIDTH-1:0]                rom_data,
   output logic [C_ADDR_WIDTH-1:0]                m_axi_awaddr,
   output logic [2:0]                             m_axi_awprot,
   output logic                                   m_axi_awvalid,
   input  logic                                   m_axi_awready,
   output logic [C_DATA_WIDTH-1:0]                m_axi_wdata,
   output logic [C_DATA_WIDTH/8-1:0]              m_axi_wstrb,
   output logic                                   m_axi_wvalid,
   input  logic                                   m_axi_wready,
   input  logic [1:0]                             m_axi_bresp,
   input  logic                                   m_axi_bvalid,
   output logic                                   m_axi_bready
);

   localparam int IDX_W  = C_ADDR_WIDTH - 2;
   localparam int STRB_W = C_DATA_WIDTH / 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REG - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      ISSUE = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t                    state_r;
   state_t                    state_nxt_s;
   logic [IDX_W-1:0]          idx_r;
   logic [IDX_W-1:0]          idx_nxt_s;
   logic [C_PSEL_WIDTH-1:0]   preset_r;
   logic [C_PSEL_WIDTH-1:0]   preset_nxt_s;
   logic                      busy_r;
   logic                      busy_nxt_s;
   logic                      done_r;
   logic                      done_nxt_s;
   logic                      err_r;
   logic                      err_nxt_s;
   logic [IDX_W-1:0]          err_idx_r;
   logic [IDX_W-1:0]          err_idx_nxt_s;
   logic                      rom_en_r;
   logic                      rom_en_nxt_s;
   logic [C_ADDR_WIDTH-1:0]   awaddr_r;
   logic [C_ADDR_WIDTH-1:0]   awaddr_nxt_s;
   logic                      awvalid_r;
   logic                      awvalid_nxt_s;
   logic [C_DATA_WIDTH-1:0]   wdata_r;
   logic [C_DATA_WIDTH-1:0]   wdata_nxt_s;
   logic                      wvalid_r;
   logic                      wvalid_nxt_s;
   logic                      bready_r;
   logic                      bready_nxt_s;

   logic                      aw_hs_s;
   logic                      w_hs_s;
   logic                      b_hs_s;
   logic                      aw_ok_s;
   logic                      w_ok_s;
   logic                      last_s;
   logic                      bresp_ok_s;
   logic                      timeout_s;

   assign aw_hs_s    = awvalid_r & m_axi_awready;
   assign w_hs_s     = wvalid_r & m_axi_wready;
   assign b_hs_s     = bready_r & m_axi_bvalid;
   // A channel is finished once its valid has dropped or its handshake lands this cycle.
   assign aw_ok_s    = ~awvalid_r | m_axi_awready;
   assign w_ok_s     = ~wvalid_r | m_axi_wready;
   assign last_s     = (idx_r == LAST_IDX);
   assign bresp_ok_s = (m_axi_bresp == 2'b00);

`ifdef LOADER_TIMEOUT_EN
   localparam int WD_W = ($clog2(C_TIMEOUT + 1) > 8) ? $clog2(C_TIMEOUT + 1) : 8;
   logic [WD_W-1:0] wd_cnt_r;

   // Watchdog: counts cycles spent in ISSUE/RESP, restarting on every state change.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if (state_nxt_s != state_r) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if ((state_r == ISSUE) || (state_r == RESP)) begin
         wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
      end else begin
         wd_cnt_r <= {WD_W{1'b0}};
      end
   end

   assign timeout_s = ((state_r == ISSUE) || (state_r == RESP)) &&
                      (wd_cnt_r == WD_W'(C_TIMEOUT - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: state_nxt_s = LATCH;
         LATCH: state_nxt_s = ISSUE;
         ISSUE: begin
            if (aw_ok_s && w_ok_s) begin
               state_nxt_s = RESP;
            end else if (timeout_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         RESP: begin
            if (b_hs_s) begin
               if (!bresp_ok_s || last_s) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = FETCH;
               end
            end else if (timeout_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output / datapath next values; every output is registered from these.
   always_comb begin
      idx_nxt_s     = idx_r;
      preset_nxt_s  = preset_r;
      busy_nxt_s    = busy_r;
      done_nxt_s    = 1'b0;
      err_nxt_s     = err_r;
      err_idx_nxt_s = err_idx_r;
      rom_en_nxt_s  = (state_nxt_s == FETCH);
      awaddr_nxt_s  = awaddr_r;
      awvalid_nxt_s = awvalid_r;
      wdata_nxt_s   = wdata_r;
      wvalid_nxt_s  = wvalid_r;
      bready_nxt_s  = bready_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               preset_nxt_s  = preset_sel;
               idx_nxt_s     = {IDX_W{1'b0}};
               err_nxt_s     = 1'b0;
               err_idx_nxt_s = {IDX_W{1'b0}};
               busy_nxt_s    = 1'b1;
            end else begin
               busy_nxt_s    = 1'b0;
            end
         end
         FETCH: begin
            busy_nxt_s = 1'b1;
         end
         LATCH: begin
            wdata_nxt_s   = rom_data;
            awaddr_nxt_s  = {idx_r, 2'b00};
            awvalid_nxt_s = 1'b1;
            wvalid_nxt_s  = 1'b1;
         end
         ISSUE: begin
            if (aw_hs_s) begin
               awvalid_nxt_s = 1'b0;
            end else begin
               awvalid_nxt_s = awvalid_r;
            end
            if (w_hs_s) begin
               wvalid_nxt_s = 1'b0;
            end else begin
               wvalid_nxt_s = wvalid_r;
            end
            if (state_nxt_s == RESP) begin
               bready_nxt_s = 1'b1;
            end else if (state_nxt_s == IDLE) begin
               awvalid_nxt_s = 1'b0;
               wvalid_nxt_s  = 1'b0;
               err_nxt_s     = 1'b1;
               err_idx_nxt_s = idx_r;
               done_nxt_s    = 1'b1;
               busy_nxt_s    = 1'b0;
            end else begin
               bready_nxt_s  = bready_r;
            end
         end
         RESP: begin
            if (b_hs_s) begin
               bready_nxt_s = 1'b0;
               if (!bresp_ok_s) begin
                  err_nxt_s     = 1'b1;
                  err_idx_nxt_s = idx_r;
                  done_nxt_s    = 1'b1;
                  busy_nxt_s    = 1'b0;
               end else if (last_s) begin
                  done_nxt_s    = 1'b1;
                  busy_nxt_s    = 1'b0;
               end else begin
                  idx_nxt_s     = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else if (timeout_s) begin
               bready_nxt_s  = 1'b0;
               err_nxt_s     = 1'b1;
               err_idx_nxt_s = idx_r;
               done_nxt_s    = 1'b1;
               busy_nxt_s    = 1'b0;
            end else begin
               bready_nxt_s  = bready_r;
            end
         end
         default: begin
            awvalid_nxt_s = 1'b0;
            wvalid_nxt_s  = 1'b0;
            bready_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b0;
         end
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         idx_r     <= {IDX_W{1'b0}};
         preset_r  <= {C_PSEL_WIDTH{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         err_idx_r <= {IDX_W{1'b0}};
         rom_en_r  <= 1'b0;
         awaddr_r  <= {C_ADDR_WIDTH{1'b0}};
         awvalid_r <= 1'b0;
         wdata_r   <= {C_DATA_WIDTH{1'b0}};
         wvalid_r  <= 1'b0;
         bready_r  <= 1'b0;
      end else begin
         idx_r     <= idx_nxt_s;
         preset_r  <= preset_nxt_s;
         busy_r    <= busy_nxt_s;
         done_r    <= done_nxt_s;
         err_r     <= err_nxt_s;
         err_idx_r <= err_idx_nxt_s;
         rom_en_r  <= rom_en_nxt_s;
         awaddr_r  <= awaddr_nxt_s;
         awvalid_r <= awvalid_nxt_s;
         wdata_r   <= wdata_nxt_s;
         wvalid_r  <= wvalid_nxt_s;
         bready_r  <= bready_nxt_s;
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign err           = err_r;
   assign err_idx       = err_idx_r;
   assign rom_addr      = {preset_r, idx_r};
   assign rom_en        = rom_en_r;
   assign m_axi_awaddr  = awaddr_r;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_r;
   assign m_axi_wdata   = wdata_r;
   assign m_axi_wstrb   = {STRB_W{1'b1}};
   assign m_axi_wvalid  = wvalid_r;
   assign m_axi_bready  = bready_r;

endmodule

// File: tb/tb_axi_lite_preset_loader.sv
// Bench for axi_lite_preset_loader: ROM model, configurable AXI-Lite slave, table of load scenarios
// plus hand-written sequences for busy-start, mid-load reset and (with LOADER_TIMEOUT_EN) the watchdog.
module tb_axi_lite_preset_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  preset_sel;
   logic        busy;
   logic        done;
   logic        err;
   logic [5:0]  err_idx;
   logic [8:0]  rom_addr;
   logic        rom_en;
   logic [31:0] rom_data = 32'd0;
   logic [7:0]  m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;

   axi_lite_preset_loader #(.C_TIMEOUT(16)) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .start         (start),
      .preset_sel    (preset_sel),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_idx       (err_idx),
      .rom_addr      (rom_addr),
      .rom_en        (rom_en),
      .rom_data      (rom_data),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ROM word for {preset, idx} is preset<<8 | idx.
   always @(posedge clk) begin
      if (rom_en) rom_data <= (32'(rom_addr[8:6]) << 8) | 32'(rom_addr[5:0]);
   end

   // Slave configuration, driven from the test process.
   logic       bv_en;
   logic       err_en;
   logic [7:0] err_addr;
   logic [7:0] dly_addr;
   int         aw_dly;
   int         w_dly;

   int aw_wcnt = 0;
   int w_wcnt  = 0;
   assign m_axi_awready = m_axi_awvalid && (aw_wcnt >= ((m_axi_awaddr == dly_addr) ? aw_dly : 0));
   assign m_axi_wready  = m_axi_wvalid  && (w_wcnt  >= ((m_axi_awaddr == dly_addr) ? w_dly  : 0));

   always @(posedge clk) begin
      aw_wcnt <= (m_axi_awvalid && !m_axi_awready) ? aw_wcnt + 1 : 0;
      w_wcnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_wcnt  + 1 : 0;
   end

   logic        got_aw;
   logic        got_w;
   logic [7:0]  aw_lat;
   logic [31:0] w_lat;
   logic [7:0]  log_addr [0:1023];
   logic [31:0] log_data [0:1023];
   int          wr_n   = 0;
   int          aw_tot = 0;
   int          w_tot  = 0;

   wire         aw_hs   = m_axi_awvalid && m_axi_awready;
   wire         w_hs    = m_axi_wvalid && m_axi_wready;
   wire         both    = (got_aw || aw_hs) && (got_w || w_hs);
   wire [7:0]   cur_a   = aw_hs ? m_axi_awaddr : aw_lat;
   wire [31:0]  cur_d   = w_hs ? m_axi_wdata : w_lat;

   // Slave: records each completed write and answers with B one cycle after both handshakes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         got_aw       <= 1'b0;
         got_w        <= 1'b0;
         m_axi_bvalid <= 1'b0;
         m_axi_bresp  <= 2'b00;
         aw_lat       <= 8'd0;
         w_lat        <= 32'd0;
      end else begin
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         if (aw_hs) aw_tot <= aw_tot + 1;
         if (w_hs)  w_tot  <= w_tot + 1;
         if (both) begin
            got_aw         <= 1'b0;
            got_w          <= 1'b0;
            log_addr[wr_n] <= cur_a;
            log_data[wr_n] <= cur_d;
            wr_n           <= wr_n + 1;
            if (bv_en) begin
               m_axi_bvalid <= 1'b1;
               m_axi_bresp  <= (err_en && (cur_a == err_addr)) ? 2'b11 : 2'b00;
            end
         end else begin
            if (aw_hs) begin
               got_aw <= 1'b1;
               aw_lat <= m_axi_awaddr;
            end
            if (w_hs) begin
               got_w <= 1'b1;
               w_lat <= m_axi_wdata;
            end
         end
      end
   end

   // Protocol monitor: valid withdrawn or payload changed before handshake; AW-only cycles.
   logic        p_awv = 1'b0;
   logic        p_awr = 1'b0;
   logic        p_wv  = 1'b0;
   logic        p_wr  = 1'b0;
   logic [7:0]  p_awa = 8'd0;
   logic [31:0] p_wd  = 32'd0;
   int          viol    = 0;
   int          split_n = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_awv <= 1'b0;
         p_wv  <= 1'b0;
      end else begin
         if ((p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awa)) ||
             (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata !== p_wd)))
            viol <= viol + 1;
         if (m_axi_awvalid && !m_axi_wvalid) split_n <= split_n + 1;
         p_awv <= m_axi_awvalid;
         p_awr <= m_axi_awready;
         p_awa <= m_axi_awaddr;
         p_wv  <= m_axi_wvalid;
         p_wr  <= m_axi_wready;
         p_wd  <= m_axi_wdata;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic start_load(input logic [2:0] p);
      @(negedge clk);
      preset_sel = p;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic chk_words(input string name, input int base, input int n, input logic [2:0] p);
      for (int i = 0; i < n; i++) begin
         chk(name, {24'd0, log_addr[base + i], log_data[base + i]},
             {24'd0, 8'(i * 4), 32'((int'(p) << 8) | i)});
      end
   endtask

   typedef struct {
      logic [2:0] preset;
      int         err_at;
      logic [7:0] dly_addr;
      int         aw_dly;
      int         w_dly;
      int         exp_n;
      logic       exp_err;
      int         exp_err_idx;
      int         exp_cyc;
      int         exp_split;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int cyc;
      int base_n;
      int base_aw;
      int base_w;
      int base_split;

      vecs[0] = '{3'd3, -1, 8'h14, 0, 0, 33, 1'b0, 0,  132, 0};
      vecs[1] = '{3'd5, -1, 8'h14, 3, 0, 33, 1'b0, 0,  135, 3};
      vecs[2] = '{3'd7, 32, 8'h00, 0, 0, 33, 1'b1, 32, 132, 0};
      vecs[3] = '{3'd0, 0,  8'h00, 0, 0, 1,  1'b1, 0,  4,   0};
      vecs[4] = '{3'd1, 10, 8'h00, 0, 0, 11, 1'b1, 10, 44,  0};
      vecs[5] = '{3'd6, -1, 8'h00, 0, 2, 33, 1'b0, 0,  134, 0};
      vecs[6] = '{3'd2, -1, 8'h80, 2, 4, 33, 1'b0, 0,  136, 0};

      rst_n = 1'b0; start = 1'b0; preset_sel = 3'd0;
      bv_en = 1'b1; err_en = 1'b0; err_addr = 8'd0; dly_addr = 8'd0; aw_dly = 0; w_dly = 0;
      repeat (3) @(negedge clk);
      chk("reset_ctl", {busy, done, err, rom_en, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 64'd0);
      chk("reset_addr", {err_idx, rom_addr, m_axi_awaddr, m_axi_wdata}, 64'd0);
      chk("awprot_wstrb", {m_axi_awprot, m_axi_wstrb}, 64'h0F);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         err_en   = (vecs[v].err_at >= 0);
         err_addr = 8'(vecs[v].err_at * 4);
         dly_addr = vecs[v].dly_addr;
         aw_dly   = vecs[v].aw_dly;
         w_dly    = vecs[v].w_dly;
         base_n = wr_n; base_aw = aw_tot; base_w = w_tot; base_split = split_n;
         start_load(vecs[v].preset);
         chk("busy_after_start", busy, 1);
         wait_done(cyc);
         chk("done_seen", done, 1);
         chk("load_cycles", cyc, vecs[v].exp_cyc);
         chk("busy_at_done", busy, 0);
         chk("err", err, vecs[v].exp_err);
         chk("err_idx", err_idx, vecs[v].exp_err_idx);
         @(negedge clk);
         chk("done_pulse", done, 0);
         repeat (5) @(negedge clk);
         chk("write_count", wr_n - base_n, vecs[v].exp_n);
         chk("aw_count", aw_tot - base_aw, vecs[v].exp_n);
         chk("w_count", w_tot - base_w, vecs[v].exp_n);
         chk("aw_only_cycles", split_n - base_split, vecs[v].exp_split);
         chk_words("word", base_n, vecs[v].exp_n, vecs[v].preset);
      end
      err_en = 1'b0; aw_dly = 0; w_dly = 0;

      // Start and preset_sel changes while busy must not disturb the running load.
      base_n = wr_n;
      start_load(3'd4);
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 20) begin
            start = 1'b1; preset_sel = 3'd2;
         end else if (cyc == 21) begin
            start = 1'b0; preset_sel = 3'd5;
         end
      end
      chk("busy_start_done", done, 1);
      chk("busy_start_cycles", cyc, 132);
      repeat (5) @(negedge clk);
      chk("busy_start_count", wr_n - base_n, 33);
      chk_words("busy_start_word", base_n, 33, 3'd4);

      // Reset while idx 10 is stuck in ISSUE, then reload from idx 0.
      dly_addr = 8'h28; aw_dly = 50;
      start_load(3'd6);
      cyc = 0;
      while (!(m_axi_awvalid === 1'b1 && m_axi_awaddr === 8'h28) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_idx10", {m_axi_awvalid, m_axi_awaddr}, {1'b1, 8'h28});
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_issue", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      aw_dly = 0;
      @(negedge clk);
      base_n = wr_n;
      start_load(3'd3);
      wait_done(cyc);
      chk("reload_cycles", cyc, 132);
      chk("reload_err", err, 0);
      repeat (5) @(negedge clk);
      chk("reload_count", wr_n - base_n, 33);
      chk_words("reload_word", base_n, 33, 3'd3);

`ifdef LOADER_TIMEOUT_EN
      // B never arrives on idx 0: watchdog fires after 16 cycles in RESP.
      bv_en = 1'b0;
      start_load(3'd0);
      wait_done(cyc);
      chk("wd_done", done, 1);
      chk("wd_cycles", cyc, 19);
      chk("wd_err", {err, err_idx}, {1'b1, 6'd0});
      chk("wd_bready", {m_axi_bready, m_axi_awvalid, m_axi_wvalid, busy}, 64'd0);
      bv_en = 1'b1;
      repeat (5) @(negedge clk);
`endif

      chk("protocol_violations", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
